// File: rtl/sdpram_stream_reader_if.sv
// Bus bundle for sdpram_stream_reader: SDPRAM read port plus the outgoing valid/ready stream.
// The master is the reader; the slave side is the RAM together with the downstream sink.
interface sdpram_stream_reader_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic                  ram_rd_clk_en;
  logic                  ram_rd_oce;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output ram_rd_addr, ram_rd_clk_en, ram_rd_oce,
    input  ram_rd_data,
    output m_data, m_valid, m_last,
    input  m_ready
  );

  modport slave (
    input  ram_rd_addr, ram_rd_clk_en, ram_rd_oce,
    output ram_rd_data,
    input  m_data, m_valid, m_last,
    output m_ready
  );
endinterface

// File: rtl/sdpram_stream_reader.sv
// Reads a contiguous SDPRAM address range and presents it as a valid/ready stream with a last
// marker; a credit-gated skid FIFO absorbs the RAM read latency under back-pressure.
module sdpram_stream_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_rd_clk,
  input  logic                  i_rd_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  output logic                  o_busy,
  output logic                  o_done,
  sdpram_stream_reader_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [PW-1:0]         PTR_ONE  = 1;
  localparam logic [CW-1:0]         CNT_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [RD_LATENCY-1:0] r_vld_pipe;
  logic [RD_LATENCY-1:0] r_last_pipe;
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic [CW-1:0]         w_inflight;
  logic                  w_credit;
  logic                  w_latch;
  logic                  w_issue;
  logic                  w_issue_last;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic                  w_push;
  logic                  w_pop;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      w_inflight = w_inflight + {{(CW-1){1'b0}}, r_vld_pipe[i]};
    end
  end

  assign w_credit = (int'(r_count) + int'(w_inflight) + 1) <= FIFO_DEPTH;
  assign w_latch  = (r_state == S_IDLE) && i_start && (i_length != '0);
  assign w_push   = r_vld_pipe[RD_LATENCY-1];
  assign w_pop    = bus.m_valid && bus.m_ready;

  // The first read goes out in the same cycle start is accepted, which is what lets the
  // first word reach m_valid RD_LATENCY+1 cycles after start.
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_issue_last = 1'b0;
    w_issue_addr = r_addr;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_length == '0) begin
            w_state_next = S_DONE;
          end else begin
            w_issue      = w_credit;
            w_issue_last = (i_length == LEN_ONE);
            w_issue_addr = i_base_addr;
            w_state_next = S_READ;
          end
        end
      end
      S_READ: begin
        w_issue      = w_credit && (r_remaining != '0);
        w_issue_last = (r_remaining == LEN_ONE);
        if ((r_remaining == '0) || (w_issue && w_issue_last)) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && bus.m_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_fifo_last <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_data[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;

      if (w_latch) begin
        r_addr      <= w_issue ? i_base_addr + ADDR_ONE : i_base_addr;
        r_remaining <= w_issue ? i_length - LEN_ONE : i_length;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_ONE;
        r_remaining <= r_remaining - LEN_ONE;
      end

      // Valid and last bits ride alongside the read so they line up with ram_rd_data.
      r_vld_pipe[0]  <= w_issue;
      r_last_pipe[0] <= w_issue && w_issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end

      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= bus.ram_rd_data;
        r_fifo_last[r_wr_ptr] <= r_last_pipe[RD_LATENCY-1];
        r_wr_ptr              <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.ram_rd_addr   = w_issue_addr;
  assign bus.ram_rd_clk_en = ~i_rd_rst;
  assign bus.ram_rd_oce    = ~i_rd_rst;
  assign bus.m_valid       = (r_count != '0);
  assign bus.m_data        = r_fifo_data[r_rd_ptr];
  assign bus.m_last        = r_fifo_last[r_rd_ptr];
  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = (r_state == S_DONE);

endmodule

// File: tb/tb_sdpram_stream_reader.sv
// Bench for sdpram_stream_reader: one instance with RD_LATENCY=2 and one with RD_LATENCY=1 share
// the command inputs and m_ready; each streams from a RAM model holding mem[a] = ~a[7:0].
module tb_sdpram_stream_reader;
  localparam int AW    = 9;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] base;
    int            len;
    int            readyMode;
    int            injectAt;
    int            expFirst2;
    int            expFirst1;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] baseAddr;
  logic [AW:0]   lenIn;
  logic          readyIn;
  logic          busy2, done2, busy1, done1;
  logic [DW-1:0] ramStage2, ramOut2, ramOut1;
  int            total = 0;
  int            bad   = 0;
  beat_t         exp2[$];
  beat_t         exp1[$];

  always #5 clk = ~clk;

  sdpram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
  sdpram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  sdpram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .FIFO_DEPTH(DEPTH)) dut2 (
    .i_rd_clk(clk), .i_rd_rst(rst), .i_start(start), .i_base_addr(baseAddr), .i_length(lenIn),
    .o_busy(busy2), .o_done(done2), .bus(bus2)
  );

  sdpram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) dut1 (
    .i_rd_clk(clk), .i_rd_rst(rst), .i_start(start), .i_base_addr(baseAddr), .i_length(lenIn),
    .o_busy(busy1), .o_done(done1), .bus(bus1)
  );

  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    return ~a[7:0];
  endfunction

  // RAM models: latency 2 uses an output register gated by oce, latency 1 does not.
  always @(posedge clk) begin
    if (bus2.ram_rd_clk_en) ramStage2 <= memWord(bus2.ram_rd_addr);
    if (bus2.ram_rd_oce)    ramOut2   <= ramStage2;
    if (bus1.ram_rd_clk_en) ramOut1   <= memWord(bus1.ram_rd_addr);
  end

  assign bus2.ram_rd_data = ramOut2;
  assign bus1.ram_rd_data = ramOut1;
  assign bus2.m_ready     = readyIn;
  assign bus1.m_ready     = readyIn;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic pickReady(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (c >= 10 && c < 30) return 1'b0;
    return logic'($urandom % 2);
  endfunction

  // Runs one command against both instances and scores the streams against the reference queues.
  task automatic applyStimulus(input vec_t v);
    int            cyc, endCyc;
    int            first2, first1, last2, last1, doneC2, doneC1;
    int            cnt2, cnt1, doneN2, doneN1;
    logic [AW-1:0] addrBefore2, addrBefore1;
    beat_t         b;

    exp2.delete();
    exp1.delete();
    for (int i = 0; i < v.len; i++) begin
      b.data = 8'hFF - 8'((int'(v.base) + i) % 256);
      b.last = (i == v.len - 1);
      exp2.push_back(b);
      exp1.push_back(b);
    end

    @(posedge clk); #1;
    addrBefore2 = bus2.ram_rd_addr;
    addrBefore1 = bus1.ram_rd_addr;
    start    = 1'b1;
    baseAddr = v.base;
    lenIn    = (AW+1)'(v.len);
    readyIn  = pickReady(v.readyMode, 0);
    @(posedge clk); #1;
    start   = 1'b0;
    readyIn = pickReady(v.readyMode, 1);

    cyc = 0; endCyc = 4000;
    first2 = -1; first1 = -1; last2 = -1; last1 = -1; doneC2 = -1; doneC1 = -1;
    cnt2 = 0; cnt1 = 0; doneN2 = 0; doneN1 = 0;
    while (cyc < endCyc) begin
      @(negedge clk);
      cyc++;
      if (bus2.m_valid && first2 < 0) first2 = cyc;
      if (bus1.m_valid && first1 < 0) first1 = cyc;
      if (bus2.m_valid && readyIn) begin
        if (exp2.size() > 0) begin
          b = exp2.pop_front();
          checkOutput("L2 data", bus2.m_data, b.data);
          checkOutput("L2 last", bus2.m_last, b.last);
        end
        if (bus2.m_last) last2 = cyc;
        cnt2++;
      end
      if (bus1.m_valid && readyIn) begin
        if (exp1.size() > 0) begin
          b = exp1.pop_front();
          checkOutput("L1 data", bus1.m_data, b.data);
          checkOutput("L1 last", bus1.m_last, b.last);
        end
        if (bus1.m_last) last1 = cyc;
        cnt1++;
      end
      if (done2) begin doneN2++; doneC2 = cyc; end
      if (done1) begin doneN1++; doneC1 = cyc; end
      if (cyc == 1) begin
        checkOutput("L2 busy after start", busy2, 1);
        checkOutput("L1 busy after start", busy1, 1);
      end
      if (v.len == 0) begin
        checkOutput("L2 len0 addr held", bus2.ram_rd_addr, addrBefore2);
        checkOutput("L1 len0 addr held", bus1.ram_rd_addr, addrBefore1);
      end
      if (doneC2 >= 0 && doneC1 >= 0 && endCyc > cyc + 3) endCyc = cyc + 3;
      @(posedge clk); #1;
      start = (v.injectAt == cyc + 1);
      if (start) begin
        baseAddr = 9'h100;
        lenIn    = 10'd5;
      end
      readyIn = pickReady(v.readyMode, cyc + 1);
    end
    start = 1'b0;

    checkOutput("L2 beat count", cnt2, v.len);
    checkOutput("L1 beat count", cnt1, v.len);
    checkOutput("L2 words left", exp2.size(), 0);
    checkOutput("L1 words left", exp1.size(), 0);
    checkOutput("L2 done pulses", doneN2, 1);
    checkOutput("L1 done pulses", doneN1, 1);
    checkOutput("L2 first valid", first2, v.expFirst2);
    checkOutput("L1 first valid", first1, v.expFirst1);
    checkOutput("L2 done cycle", doneC2, (v.len == 0) ? 1 : last2 + 1);
    checkOutput("L1 done cycle", doneC1, (v.len == 0) ? 1 : last1 + 1);
    if (v.readyMode == 0 && v.len > 0) begin
      checkOutput("L2 throughput", last2 - first2, v.len - 1);
      checkOutput("L1 throughput", last1 - first1, v.len - 1);
    end
  endtask

  // Reset pulsed in the middle of a long read: everything clears and stays quiet.
  task automatic midCommandReset();
    int sawDone, sawValid;
    @(posedge clk); #1;
    start = 1'b1; baseAddr = 9'h000; lenIn = 10'd64; readyIn = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("L2 busy after reset", busy2, 0);
    checkOutput("L1 busy after reset", busy1, 0);
    checkOutput("L2 valid after reset", bus2.m_valid, 0);
    checkOutput("L1 valid after reset", bus1.m_valid, 0);
    sawDone = 0; sawValid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done2 || done1) sawDone++;
      if (bus2.m_valid || bus1.m_valid) sawValid++;
    end
    checkOutput("no done after reset", sawDone, 0);
    checkOutput("no valid after reset", sawValid, 0);
  endtask

  initial begin
    vec_t vecs[8];
    vec_t v;

    vecs[0] = '{base: 9'h000, len: 16,  readyMode: 0, injectAt: 0, expFirst2: 3,  expFirst1: 2};
    vecs[1] = '{base: 9'h1FE, len: 4,   readyMode: 0, injectAt: 0, expFirst2: 3,  expFirst1: 2};
    vecs[2] = '{base: 9'h0A0, len: 32,  readyMode: 1, injectAt: 0, expFirst2: 3,  expFirst1: 2};
    vecs[3] = '{base: 9'h100, len: 0,   readyMode: 0, injectAt: 0, expFirst2: -1, expFirst1: -1};
    vecs[4] = '{base: 9'h040, len: 8,   readyMode: 0, injectAt: 3, expFirst2: 3,  expFirst1: 2};
    vecs[5] = '{base: 9'h005, len: 512, readyMode: 0, injectAt: 0, expFirst2: 3,  expFirst1: 2};
    vecs[6] = '{base: 9'h1FF, len: 1,   readyMode: 1, injectAt: 0, expFirst2: 3,  expFirst1: 2};
    vecs[7] = '{base: 9'h133, len: 32,  readyMode: 1, injectAt: 0, expFirst2: 3,  expFirst1: 2};

    rst = 1'b1; start = 1'b0; baseAddr = '0; lenIn = '0; readyIn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("L2 reset busy",   busy2, 0);
    checkOutput("L1 reset busy",   busy1, 0);
    checkOutput("L2 reset done",   done2, 0);
    checkOutput("L1 reset done",   done1, 0);
    checkOutput("L2 reset valid",  bus2.m_valid, 0);
    checkOutput("L1 reset valid",  bus1.m_valid, 0);
    checkOutput("L2 reset last",   bus2.m_last, 0);
    checkOutput("L1 reset last",   bus1.m_last, 0);
    checkOutput("L2 reset data",   bus2.m_data, 0);
    checkOutput("L1 reset data",   bus1.m_data, 0);
    checkOutput("L2 reset addr",   bus2.ram_rd_addr, 0);
    checkOutput("L1 reset addr",   bus1.ram_rd_addr, 0);
    checkOutput("L2 clk_en",       bus2.ram_rd_clk_en, 1);
    checkOutput("L1 clk_en",       bus1.ram_rd_clk_en, 1);
    checkOutput("L2 oce",          bus2.ram_rd_oce, 1);
    checkOutput("L1 oce",          bus1.ram_rd_oce, 1);

    for (int i = 0; i < 8; i++) begin
      $display("[TB] command %0d: base=0x%0h len=%0d", i, vecs[i].base, vecs[i].len);
      applyStimulus(vecs[i]);
    end

    midCommandReset();
    v = '{base: 9'h010, len: 2, readyMode: 0, injectAt: 0, expFirst2: 3, expFirst1: 2};
    applyStimulus(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
